// File: rtl/button_reader_mmio.sv
// Read-side MMIO slot for board push-buttons: per-pin sync + debounce, sticky press
// flags (W1C), saturating press counter. Optional press interrupt with mask under BTN_IRQ_EN.
module button_reader_mmio #(
   parameter int unsigned N_BTN     = 4,
   parameter int unsigned DB_CYCLES = 1000000,
   parameter int unsigned CNT_W     = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cs,
   input  logic             rd_en,
   input  logic             wr_en,
   input  logic [1:0]       address,
   input  logic [15:0]      wr_data,
   output logic [15:0]      rd_data,
   input  logic [N_BTN-1:0] btn,
   output logic             irq
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [15:0]      CNT_MAX = 16'hFFFF;

   logic [N_BTN-1:0] sync1_q, sync2_q;
   logic [N_BTN-1:0] deb_q, deb_d;
   logic [CNT_W-1:0] db_cnt_q [N_BTN];
   logic [CNT_W-1:0] db_cnt_d [N_BTN];
   logic [N_BTN-1:0] edge_q, edge_d;
   logic [15:0]      press_cnt_q, press_cnt_d;
   logic [N_BTN-1:0] rise_c;
   logic [15:0]      mask_rd_c;
   logic             wr_c;
   logic             unused_c;

   assign wr_c     = cs & wr_en;
   assign unused_c = ^{rd_en, wr_data};

   // Debounce: a level change is accepted only after DB_CYCLES consecutive differing samples.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < int'(N_BTN); i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) deb_d[i] = sync2_q[i];
            else                        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
         end
      end
   end

   assign rise_c = deb_d & ~deb_q;

   // A rise on the same edge as a W1C keeps the flag set.
   always_comb begin
      edge_d = edge_q;
      if (wr_c && address == 2'd1) edge_d = edge_q & ~wr_data[N_BTN-1:0];
      edge_d = edge_d | rise_c;
   end

   always_comb begin
      press_cnt_d = press_cnt_q;
      if (wr_c && address == 2'd2)
         press_cnt_d = (|rise_c) ? 16'd1 : 16'd0;
      else if ((|rise_c) && press_cnt_q != CNT_MAX)
         press_cnt_d = press_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         deb_q       <= '0;
         edge_q      <= '0;
         press_cnt_q <= '0;
         for (int i = 0; i < int'(N_BTN); i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q     <= btn;
         sync2_q     <= sync1_q;
         deb_q       <= deb_d;
         edge_q      <= edge_d;
         press_cnt_q <= press_cnt_d;
         for (int i = 0; i < int'(N_BTN); i++) db_cnt_q[i] <= db_cnt_d[i];
      end
   end

`ifdef BTN_IRQ_EN
   logic [N_BTN-1:0] mask_q, mask_d;
   logic             irq_q;

   always_comb begin
      mask_d = mask_q;
      if (wr_c && address == 2'd3) mask_d = wr_data[N_BTN-1:0];
   end

   // Interrupt follows the registered flag/mask state by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         mask_q <= mask_d;
         irq_q  <= |(edge_q & mask_q);
      end
   end

   assign mask_rd_c = 16'(mask_q);
   assign irq       = irq_q;
`else
   assign mask_rd_c = 16'd0;
   assign irq       = 1'b0;
`endif

   always_comb begin
      rd_data = '0;
      if (cs) begin
         case (address)
            2'd0:    rd_data = 16'(deb_q);
            2'd1:    rd_data = 16'(edge_q);
            2'd2:    rd_data = press_cnt_q;
            default: rd_data = mask_rd_c;
         endcase
      end
   end

endmodule

// File: tb/tb_button_reader_mmio.sv
// Bench for button_reader_mmio (N_BTN=4, DB_CYCLES=8): directed scenarios plus randomized
// pin/bus traffic against a sample-history reference model.
module tb_button_reader_mmio;

   localparam int unsigned N  = 4;
   localparam int unsigned DB = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs, rd_en, wr_en;
   logic [1:0]  address;
   logic [15:0] wr_data;
   logic [15:0] rd_data;
   logic [3:0]  btn;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: pin delay line, history of synchronized samples, architectural regs.
   logic [3:0]  m_s1, m_s, m_deb, m_edge, m_mask;
   logic [15:0] m_cnt;
   logic        m_irq;
   logic [3:0]  m_hist[$];

   button_reader_mmio #(.N_BTN(N), .DB_CYCLES(DB), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .cs(cs), .rd_en(rd_en), .wr_en(wr_en), .address(address),
      .wr_data(wr_data), .rd_data(rd_data), .btn(btn), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic model_reset();
      m_s1 = '0; m_s = '0; m_deb = '0; m_edge = '0; m_mask = '0; m_cnt = '0; m_irq = 1'b0;
      m_hist.delete();
   endtask

   // A debounced bit flips once the last DB synchronized samples all disagree with it.
   function automatic logic [3:0] m_next_deb();
      logic [3:0] nd;
      nd = m_deb;
      for (int b = 0; b < int'(N); b++) begin
         logic all_diff;
         all_diff = (m_hist.size() >= int'(DB));
         for (int j = 0; j < int'(DB); j++)
            if (all_diff && m_hist[m_hist.size() - 1 - j][b] == m_deb[b]) all_diff = 1'b0;
         if (all_diff) nd[b] = ~m_deb[b];
      end
      return nd;
   endfunction

   task automatic model_step();
      logic [3:0] nd, rise;
      logic       wr;
      nd   = m_next_deb();
      rise = nd & ~m_deb;
      wr   = cs && wr_en;
`ifdef BTN_IRQ_EN
      m_irq = |(m_edge & m_mask);
      if (wr && address == 2'd3) m_mask = wr_data[3:0];
`else
      m_irq = 1'b0;
`endif
      if (wr && address == 2'd1) m_edge = m_edge & ~wr_data[3:0];
      m_edge = m_edge | rise;
      if (wr && address == 2'd2)          m_cnt = (rise != 0) ? 16'd1 : 16'd0;
      else if (rise != 0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_deb = nd;
      m_s   = m_s1;
      m_s1  = btn;
      m_hist.push_back(m_s);
      if (m_hist.size() > int'(DB)) void'(m_hist.pop_front());
   endtask

   function automatic logic [15:0] exp_rd(input logic c, input logic [1:0] a);
      if (!c) return 16'h0000;
      case (a)
         2'd0:    return {12'h000, m_deb};
         2'd1:    return {12'h000, m_edge};
         2'd2:    return m_cnt;
`ifdef BTN_IRQ_EN
         default: return {12'h000, m_mask};
`else
         default: return 16'h0000;
`endif
      endcase
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
      cs = 1'b1; wr_en = 1'b1; address = a; wr_data = d;
      tick();
      cs = 1'b0; wr_en = 1'b0; wr_data = '0;
   endtask

   task automatic settle_low();
      btn = 4'b0000;
      repeat (12) tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int a = 0; a < 4; a++) begin
         cs = 1'b1; rd_en = 1'b1; address = 2'(a); #1;
         n_cmp++;
         if (rd_data !== 16'h0000) begin
            n_err++; $display("FAIL reset_rd%0d: got %h want 0000", a, rd_data);
         end
      end
      cs = 1'b0; rd_en = 1'b0; address = 2'd2; #1;
      n_cmp++;
      if (rd_data !== 16'h0000) begin n_err++; $display("FAIL reset_cs0: got %h want 0000", rd_data); end
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_single_press();
      btn = 4'b0001; cs = 1'b1; address = 2'd0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         n_cmp++;
         if (rd_data !== ((e >= 10) ? 16'h0001 : 16'h0000)) begin
            n_err++; $display("FAIL press_timing edge %0d: got %h want %h", e, rd_data,
                              (e >= 10) ? 16'h0001 : 16'h0000);
         end
      end
      address = 2'd1; #1;
      n_cmp++;
      if (rd_data !== 16'h0001) begin n_err++; $display("FAIL press_edge: got %h want 0001", rd_data); end
      address = 2'd2; #1;
      n_cmp++;
      if (rd_data !== 16'h0001) begin n_err++; $display("FAIL press_cnt: got %h want 0001", rd_data); end
      cs = 1'b0;
   endtask

   task automatic test_glitch();
      settle_low();
      bus_write(2'd1, 16'h000F);
      bus_write(2'd2, 16'h0000);
      cs = 1'b1; address = 2'd0;
      btn = 4'b0010;
      for (int k = 0; k < 20; k++) begin
         if (k == 5) btn = 4'b0000;
         tick();
         n_cmp++;
         if (rd_data !== 16'h0000) begin n_err++; $display("FAIL glitch_deb cyc %0d: got %h want 0000", k, rd_data); end
      end
      address = 2'd1; #1;
      n_cmp++;
      if (rd_data !== 16'h0000) begin n_err++; $display("FAIL glitch_edge: got %h want 0000", rd_data); end
      address = 2'd2; #1;
      n_cmp++;
      if (rd_data !== 16'h0000) begin n_err++; $display("FAIL glitch_cnt: got %h want 0000", rd_data); end
      cs = 1'b0;
   endtask

   task automatic test_dual_press();
      btn = 4'b0101;
      repeat (12) tick();
      cs = 1'b1; address = 2'd1; #1;
      n_cmp++;
      if (rd_data !== 16'h0005) begin n_err++; $display("FAIL dual_edge: got %h want 0005", rd_data); end
      address = 2'd2; #1;
      n_cmp++;
      if (rd_data !== 16'h0001) begin n_err++; $display("FAIL dual_cnt: got %h want 0001", rd_data); end
      bus_write(2'd1, 16'h0001);
      cs = 1'b1; address = 2'd1; #1;
      n_cmp++;
      if (rd_data !== 16'h0004) begin n_err++; $display("FAIL w1c_edge: got %h want 0004", rd_data); end
      cs = 1'b0;
   endtask

   task automatic test_saturate();
      settle_low();
      #2 force dut.press_cnt_q = 16'hFFFF;
      #1 release dut.press_cnt_q;
      m_cnt = 16'hFFFF;
      btn = 4'b1000;
      repeat (12) tick();
      cs = 1'b1; address = 2'd2; #1;
      n_cmp++;
      if (rd_data !== 16'hFFFF) begin n_err++; $display("FAIL cnt_saturate: got %h want ffff", rd_data); end
      cs = 1'b0;
   endtask

   task automatic test_simultaneous();
      logic found;
      settle_low();
      bus_write(2'd1, 16'h000F);
      btn = 4'b0100; found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if ((m_next_deb() & ~m_deb) != 0) begin
            cs = 1'b1; wr_en = 1'b1; address = 2'd2; wr_data = 16'h0000; found = 1'b1;
         end
         tick();
      end
      wr_en = 1'b0;
      if (!found) begin n_err++; $display("FAIL sim_cnt_timeout: got no rise want rise"); end
      cs = 1'b1; address = 2'd2; #1;
      n_cmp++;
      if (rd_data !== 16'h0001) begin n_err++; $display("FAIL clr_vs_inc: got %h want 0001", rd_data); end
      cs = 1'b0;
      settle_low();
      bus_write(2'd1, 16'h000F);
      btn = 4'b0100; found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if ((m_next_deb() & ~m_deb) != 0) begin
            cs = 1'b1; wr_en = 1'b1; address = 2'd1; wr_data = 16'h0004; found = 1'b1;
         end
         tick();
      end
      wr_en = 1'b0;
      if (!found) begin n_err++; $display("FAIL sim_w1c_timeout: got no rise want rise"); end
      cs = 1'b1; address = 2'd1; #1;
      n_cmp++;
      if (rd_data !== 16'h0004) begin n_err++; $display("FAIL set_vs_w1c: got %h want 0004", rd_data); end
      cs = 1'b0;
   endtask

   task automatic test_reset_mid();
      int rise_at;
      settle_low();
      btn = 4'b0001;
      repeat (7) tick();
      rst = 1'b0;
      for (int a = 0; a < 4; a++) begin
         cs = 1'b1; address = 2'(a); #1;
         n_cmp++;
         if (rd_data !== 16'h0000) begin n_err++; $display("FAIL midrst_rd%0d: got %h want 0000", a, rd_data); end
      end
      cs = 1'b0;
      #1 rst = 1'b1;
      model_reset();
      cs = 1'b1; address = 2'd0; rise_at = 0;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (rise_at == 0 && rd_data[0] === 1'b1) rise_at = e;
      end
      n_cmp++;
      if (rise_at != 10) begin n_err++; $display("FAIL midrst_relatch: got edge %0d want edge 10", rise_at); end
      cs = 1'b0;
   endtask

   task automatic test_irq();
`ifdef BTN_IRQ_EN
      logic found;
      bus_write(2'd3, 16'h0002);
      cs = 1'b1; address = 2'd3; #1;
      n_cmp++;
      if (rd_data !== 16'h0002) begin n_err++; $display("FAIL mask_rd: got %h want 0002", rd_data); end
      cs = 1'b0;
      btn = 4'b0011; found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         tick();
         if (m_edge[1]) found = 1'b1;
      end
      if (!found) begin n_err++; $display("FAIL irq_timeout: got no edge want edge"); end
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b want 0", irq); end
      tick();
      n_cmp++;
      if (irq !== 1'b1) begin n_err++; $display("FAIL irq_assert: got %b want 1", irq); end
      bus_write(2'd1, 16'h0002);
      n_cmp++;
      if (irq !== 1'b1) begin n_err++; $display("FAIL irq_hold: got %b want 1", irq); end
      tick();
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b want 0", irq); end
`else
      bus_write(2'd3, 16'hFFFF);
      btn = 4'b0011;
      repeat (12) tick();
      cs = 1'b1; address = 2'd3; #1;
      n_cmp++;
      if (rd_data !== 16'h0000) begin n_err++; $display("FAIL addr3_rd: got %h want 0000", rd_data); end
      cs = 1'b0;
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL irq_tied: got %b want 0", irq); end
`endif
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      for (int it = 0; it < 1500; it++) begin
         if (hold == 0) begin
            btn  = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 16);
         end
         hold--;
         cs      = 1'($urandom_range(0, 3) != 0);
         rd_en   = cs;
         wr_en   = ($urandom_range(0, 9) == 0);
         address = 2'($urandom_range(0, 3));
         wr_data = 16'($urandom());
         tick();
         n_cmp++;
         if (rd_data !== exp_rd(cs, address)) begin
            n_err++; $display("FAIL rand_rd it %0d addr %0d cs %b: got %h want %h", it, address, cs,
                              rd_data, exp_rd(cs, address));
         end
         n_cmp++;
         if (irq !== m_irq) begin n_err++; $display("FAIL rand_irq it %0d: got %b want %b", it, irq, m_irq); end
      end
      cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
   endtask

   initial begin
      rst = 1'b0; cs = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; wr_data = '0; btn = '0;
      model_reset();
      test_reset();
      test_single_press();
      test_glitch();
      test_dual_press();
      test_saturate();
      test_simultaneous();
      test_reset_mid();
      test_irq();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
